fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order fetch requests, queues the responses
// in a small in-order queue, and feeds the IF/ID register with stall/flush/redirect control.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_next,
  output logic [31:0] if_id_instr
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [31:0]            fetch_pc_q, fetch_pc_d;
  logic [DEPTH-1:0][31:0] qpc_q, qpc_d, qinstr_q, qinstr_d;
  logic [DEPTH-1:0]       qfilled_q, qfilled_d;
  logic [AW-1:0]          head_q, head_d, tail_q, tail_d, fidx;
  logic [CW-1:0]          count_q, count_d, unf_q, unf_d, drop_q, drop_d;
  logic                   vld_q, vld_d;
  logic [31:0]            pc_q, pc_d, pcn_q, pcn_d, instr_q, instr_d;
  logic                   req_fire, head_filled;
  logic [CW:0]            inflight;

  // In-flight accounting counts both live entries and responses still to be dropped.
  assign inflight       = {1'b0, count_q} + {1'b0, drop_q};
  assign imem_req_valid = !rst && !redirect_valid && (inflight < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign head_filled    = (count_q != '0) && qfilled_q[head_q];
  // Fills are in order, so the oldest unfilled entry sits unf_q slots behind the tail.
  assign fidx           = tail_q - unf_q[AW-1:0];

  assign if_id_valid   = vld_q;
  assign if_id_pc      = pc_q;
  assign if_id_pc_next = pcn_q;
  assign if_id_instr   = instr_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    qpc_d      = qpc_q;
    qinstr_d   = qinstr_q;
    qfilled_d  = qfilled_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    unf_d      = unf_q;
    drop_d     = drop_q;
    vld_d      = vld_q;
    pc_d       = pc_q;
    pcn_d      = pcn_q;
    instr_d    = instr_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      unf_d      = '0;
      drop_d     = drop_q + unf_q - CW'(imem_rsp_valid);
      vld_d      = 1'b0;
      instr_d    = NOP;
    end else begin
      if (imem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - ONE;
        end else begin
          qinstr_d[fidx]  = imem_rsp_data;
          qfilled_d[fidx] = 1'b1;
          unf_d           = unf_q - ONE;
        end
      end
      if (req_fire) begin
        qpc_d[tail_q]     = fetch_pc_q;
        qfilled_d[tail_q] = 1'b0;
        tail_d            = tail_q + AW'(1);
        fetch_pc_d        = fetch_pc_q + 32'd4;
        unf_d             = unf_d + ONE;
      end
      if (flush) begin
        vld_d   = 1'b0;
        instr_d = NOP;
      end else if (!stall) begin
        if (head_filled) begin
          vld_d   = 1'b1;
          pc_d    = qpc_q[head_q];
          pcn_d   = qpc_q[head_q] + 32'd4;
          instr_d = qinstr_q[head_q];
          head_d  = head_q + AW'(1);
        end else begin
          vld_d   = 1'b0;
          instr_d = NOP;
        end
      end
      count_d = count_q + CW'(req_fire) - CW'(!flush && !stall && head_filled);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      unf_q      <= '0;
      drop_q     <= '0;
      vld_q      <= 1'b0;
      pc_q       <= '0;
      pcn_q      <= '0;
      instr_q    <= NOP;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      unf_q      <= unf_d;
      drop_q     <= drop_d;
      vld_q      <= vld_d;
      pc_q       <= pc_d;
      pcn_q      <= pcn_d;
      instr_q    <= instr_d;
    end
  end

  // Queue payload needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    qpc_q     <= qpc_d;
    qinstr_q  <= qinstr_d;
    qfilled_q <= qfilled_d;
  end
endmodule
